// File: rtl/multi_alarm_timekeeper.sv
// BCD 24h timekeeper with N_ALARM alarm channels (ring / snooze / self-clear) and buzzer tone.
// Define HOURLY_CHIME_EN to build the xx:59:51..59 odd-second chime; otherwise chime is tied low.

module multi_alarm_timekeeper_chan #(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick,
    input  logic       sec_wrap,
    input  logic       wr,
    input  logic [7:0] wr_hr,
    input  logic [7:0] wr_min,
    input  logic       en,
    input  logic       snooze,
    input  logic [7:0] cur_hr,
    input  logic [7:0] cur_min,
    output logic       ringing
);
    localparam int CMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] RING_LD = CW'(RING_SEC);
    localparam logic [CW-1:0] SNZ_LD  = CW'(SNOOZE_SEC);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RING = 2'd1;
    localparam logic [1:0] S_SNZ  = 2'd2;

    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [7:0]    a_hr, a_min;
    logic          match;

    // cur_hr/cur_min are the values the time registers take at this edge
    assign match   = sec_wrap && (a_hr == cur_hr) && (a_min == cur_min);
    assign ringing = (st == S_RING);

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            st    <= S_IDLE;
            cnt   <= '0;
            a_hr  <= 8'h00;
            a_min <= 8'h00;
        end else begin
            if (wr) begin
                a_hr  <= wr_hr;
                a_min <= wr_min;
            end
            if (!en) begin
                st  <= S_IDLE;
                cnt <= '0;
            end else begin
                case (st)
                    S_IDLE: if (match) begin
                        st  <= S_RING;
                        cnt <= RING_LD;
                    end
                    S_RING: if (snooze) begin
                        st  <= S_SNZ;
                        cnt <= SNZ_LD;
                    end else if (tick) begin
                        if (cnt <= CW'(1)) begin
                            st  <= S_IDLE;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    // countdown hits zero on the tick that would take it from 1 to 0
                    S_SNZ: if (tick) begin
                        if (cnt <= CW'(1)) begin
                            st  <= S_RING;
                            cnt <= RING_LD;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: begin
                        st  <= S_IDLE;
                        cnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule

module multi_alarm_timekeeper #(
    parameter int TICK_DIV   = 1000,
    parameter int N_ALARM    = 4,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300,
    parameter int BEEP_DIV   = 2,
    localparam int SEL_W     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic               CP,
    input  logic               CR,
    input  logic               adj_min,
    input  logic               adj_hr,
    input  logic               al_wr,
    input  logic [SEL_W-1:0]   al_sel,
    input  logic [7:0]         al_hr,
    input  logic [7:0]         al_min,
    input  logic [N_ALARM-1:0] al_en,
    input  logic               snooze,
    output logic [7:0]         hour,
    output logic [7:0]         minute,
    output logic [7:0]         second,
    output logic               tick_1hz,
    output logic [N_ALARM-1:0] alarm_active,
    output logic               alarm_out,
    output logic               chime
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_DIV - 1);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [PW-1:0] presc;
    logic [7:0]    nxt_hr, nxt_min, nxt_sec;
    logic          sec_wrap, wr_ok, hr_ok, min_ok, any_ring, beep_q;
    logic [BW-1:0] beep_cnt;

    assign tick_1hz = (presc == PRE_MAX);

    always_ff @(posedge CP or posedge CR) begin
        if (CR) presc <= '0;
        else    presc <= tick_1hz ? '0 : presc + PW'(1);
    end

    // An adjust pulse owns its field for the cycle: a tick carry into it is dropped
    always_comb begin
        sec_wrap = tick_1hz && (second == 8'h59);
        nxt_sec  = tick_1hz ? bcd_inc(second, 8'h59) : second;
        nxt_min  = minute;
        if (adj_min || sec_wrap) nxt_min = bcd_inc(minute, 8'h59);
        nxt_hr   = hour;
        if (adj_hr || (sec_wrap && !adj_min && minute == 8'h59)) nxt_hr = bcd_inc(hour, 8'h23);
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            hour   <= 8'h00;
            minute <= 8'h00;
            second <= 8'h00;
        end else begin
            hour   <= nxt_hr;
            minute <= nxt_min;
            second <= nxt_sec;
        end
    end

    assign hr_ok  = (al_hr[3:0] <= 4'd9) &&
                    ((al_hr[7:4] < 4'd2) || (al_hr[7:4] == 4'd2 && al_hr[3:0] <= 4'd3));
    assign min_ok = (al_min[3:0] <= 4'd9) && (al_min[7:4] <= 4'd5);
    assign wr_ok  = al_wr && hr_ok && min_ok;

    // Out-of-range al_sel matches no instance, so the write is dropped
    for (genvar i = 0; i < N_ALARM; i++) begin : g_ch
        multi_alarm_timekeeper_chan #(
            .RING_SEC  (RING_SEC),
            .SNOOZE_SEC(SNOOZE_SEC)
        ) u_ch (
            .CP      (CP),
            .CR      (CR),
            .tick    (tick_1hz),
            .sec_wrap(sec_wrap),
            .wr      (wr_ok && (al_sel == SEL_W'(i))),
            .wr_hr   (al_hr),
            .wr_min  (al_min),
            .en      (al_en[i]),
            .snooze  (snooze),
            .cur_hr  (nxt_hr),
            .cur_min (nxt_min),
            .ringing (alarm_active[i])
        );
    end

    assign any_ring = |alarm_active;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            beep_cnt <= '0;
            beep_q   <= 1'b0;
        end else if (!any_ring) begin
            beep_cnt <= '0;
            beep_q   <= 1'b0;
        end else if (beep_cnt == BEEP_LAST) begin
            beep_cnt <= '0;
            beep_q   <= ~beep_q;
        end else begin
            beep_cnt <= beep_cnt + BW'(1);
        end
    end

    // Gate so the tone drops in the same cycle the last ring ends
    assign alarm_out = beep_q & any_ring;

`ifdef HOURLY_CHIME_EN
    always_ff @(posedge CP or posedge CR) begin
        if (CR) chime <= 1'b0;
        else    chime <= (nxt_min == 8'h59) && (nxt_sec[7:4] == 4'd5) && nxt_sec[0];
    end
`else
    assign chime = 1'b0;
`endif
endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Scoreboard bench for multi_alarm_timekeeper: expectations are queued with a due cycle and
// compared by a negedge monitor. Parameters: TICK_DIV=4, N_ALARM=4, RING_SEC=3, SNOOZE_SEC=2, BEEP_DIV=2.
module tb_multi_alarm_timekeeper;
    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic       adj_min = 1'b0, adj_hr = 1'b0, al_wr = 1'b0, snooze = 1'b0;
    logic [1:0] al_sel = 2'd0;
    logic [7:0] al_hr = 8'h00, al_min = 8'h00;
    logic [3:0] al_en = 4'b0000;
    logic [7:0] hour, minute, second;
    logic       tick_1hz, alarm_out, chime;
    logic [3:0] alarm_active;

    localparam int S_TIME = 0, S_TICK = 1, S_ACT = 2, S_OUT = 3, S_CHIME = 4;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    multi_alarm_timekeeper #(
        .TICK_DIV(4), .N_ALARM(4), .RING_SEC(3), .SNOOZE_SEC(2), .BEEP_DIV(2)
    ) dut (
        .CP(CP), .CR(CR), .adj_min(adj_min), .adj_hr(adj_hr), .al_wr(al_wr),
        .al_sel(al_sel), .al_hr(al_hr), .al_min(al_min), .al_en(al_en), .snooze(snooze),
        .hour(hour), .minute(minute), .second(second), .tick_1hz(tick_1hz),
        .alarm_active(alarm_active), .alarm_out(alarm_out), .chime(chime)
    );

    always #5 CP = ~CP;

    always @(posedge CP or posedge CR) begin
        if (CR) cyc <= 0;
        else    cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] bcd(input int x);
        return 8'((x / 10) * 16 + (x % 10));
    endfunction

    function automatic logic [31:0] t(input int h, input int m, input int s);
        return {8'h00, bcd(h), bcd(m), bcd(s)};
    endfunction

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_TIME:  return {8'h00, hour, minute, second};
            S_TICK:  return {31'd0, tick_1hz};
            S_ACT:   return {28'd0, alarm_active};
            S_OUT:   return {31'd0, alarm_out};
            default: return {31'd0, chime};
        endcase
    endfunction

    task automatic push(input int due, input int sig, input logic [31:0] val, input string tag);
        sb_t e;
        e.due = due; e.sig = sig; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge CP) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk($sformatf("%s@%0d", sb[i].tag, cyc), sample(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic goto(input int c);
        int g;
        g = 0;
        while (cyc < c && g < 5000) begin
            @(negedge CP);
            g++;
        end
        if (cyc < c) chk("goto_timeout", cyc, c);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        CR = 1'b1;
        adj_min = 0; adj_hr = 0; al_wr = 0; snooze = 0; al_en = 4'b0000;
        push(0, S_TIME, 0, "rst_time");
        push(0, S_TICK, 0, "rst_tick");
        push(0, S_ACT, 0, "rst_act");
        push(0, S_OUT, 0, "rst_out");
        push(0, S_CHIME, 0, "rst_chime");
        repeat (2) @(negedge CP);
        CR = 1'b0;
    endtask

    task automatic al_write(input logic [1:0] sel, input logic [7:0] h, input logic [7:0] m);
        al_sel = sel; al_hr = h; al_min = m; al_wr = 1'b1;
        @(negedge CP);
        al_wr = 1'b0;
    endtask

    task automatic adj_pulse(input logic do_min, input logic do_hr);
        adj_min = do_min; adj_hr = do_hr;
        @(negedge CP);
        adj_min = 1'b0; adj_hr = 1'b0;
    endtask

    task automatic snooze_pulse();
        snooze = 1'b1;
        @(negedge CP);
        snooze = 1'b0;
    endtask

    function automatic logic [31:0] chime_exp(input int c);
`ifdef HOURLY_CHIME_EN
        int s;
        s = c / 4;
        return {31'd0, (c < 240) && (s >= 51) && (s % 2 == 1)};
`else
        return {31'd0, (c < 0)};
`endif
    endfunction

    initial begin
        // free run: tick cadence and minute rollover
        do_reset();
        for (int c = 1; c <= 240; c++) push(c, S_TICK, {31'd0, (c % 4 == 3)}, "tick");
        push(4, S_TIME, t(0, 0, 1), "time_1s");
        push(239, S_TIME, t(0, 0, 59), "time_59s");
        push(240, S_TIME, t(0, 1, 0), "time_1m");
        goto(241);
        drain("run");

        // preload via adjusts, wraps, midnight rollover, chime window
        do_reset();
        push(24, S_TIME, t(0, 0, 6), "adjhr_wrap");
        push(47, S_TIME, t(23, 0, 11), "adjhr_23");
        push(106, S_TIME, t(23, 59, 26), "adjmin_59");
        push(107, S_TIME, t(23, 0, 26), "adjmin_wrap");
        push(166, S_TIME, t(23, 59, 41), "preload");
        push(232, S_TIME, t(23, 59, 58), "t_235958");
        push(236, S_TIME, t(23, 59, 59), "t_235959");
        push(240, S_TIME, t(0, 0, 0), "midnight");
        push(244, S_TIME, t(0, 0, 1), "after_mid");
        for (int c = 196; c <= 243; c++) push(c, S_CHIME, chime_exp(c), "chime");
        repeat (47) adj_pulse(1'b0, 1'b1);
        repeat (119) adj_pulse(1'b1, 1'b0);
        goto(245);
        drain("adjust");

        // ring, tone, write during ring, snooze while idle ignored
        do_reset();
        al_en = 4'b0010;
        al_write(2'd1, 8'h00, 8'h01);
        for (int c = 236; c <= 254; c++) begin
            push(c, S_ACT, (c >= 240 && c <= 251) ? 32'h2 : 32'h0, "ring_act");
            push(c, S_OUT, (c >= 240 && c <= 251) ? 32'(((c - 240) / 2) % 2) : 32'h0, "ring_out");
        end
        goto(100);
        snooze_pulse();
        goto(244);
        al_write(2'd1, 8'h00, 8'h07);
        goto(256);
        drain("ring");

        // bad writes, snooze/re-ring, disable in snooze, adjust onto alarm, adjust with carry
        do_reset();
        al_en = 4'b0110;
        al_write(2'd1, 8'h00, 8'h01);
        al_write(2'd1, 8'h24, 8'h00);
        al_write(2'd1, 8'h00, 8'h5A);
        al_write(2'd2, 8'h00, 8'h03);
        al_write(2'd3, 8'h00, 8'h01);
        push(239, S_ACT, 0, "pre_ring");
        push(240, S_ACT, 2, "ring_bad_wr");
        push(244, S_ACT, 2, "ring_pre_snz");
        push(245, S_ACT, 0, "snoozed");
        push(251, S_ACT, 0, "snz_hold");
        push(252, S_ACT, 2, "rering");
        push(253, S_ACT, 2, "rering2");
        for (int c = 254; c <= 300; c++) push(c, S_ACT, 0, "dis_snz");
        for (int c = 480; c <= 490; c++) push(c, S_ACT, 0, "adj_noring");
        push(481, S_TIME, t(0, 3, 0), "adj_onto_al");
        push(719, S_TIME, t(0, 3, 59), "pre_carry");
        push(720, S_TIME, t(1, 4, 0), "adj_carry");
        goto(244);
        snooze_pulse();
        goto(253);
        snooze_pulse();
        goto(256);
        al_en = 4'b0100;
        goto(480);
        adj_pulse(1'b1, 1'b0);
        goto(719);
        adj_pulse(1'b1, 1'b1);
        goto(721);
        drain("snooze");

        // reset mid-ring, then first tick after release
        do_reset();
        al_en = 4'b0010;
        al_write(2'd1, 8'h00, 8'h01);
        push(246, S_ACT, 2, "pre_abort_act");
        push(246, S_OUT, 1, "pre_abort_out");
        goto(246);
        #2 CR = 1'b1;
        #1;
        chk("abort_time", sample(S_TIME), 0);
        chk("abort_act", sample(S_ACT), 0);
        chk("abort_out", sample(S_OUT), 0);
        chk("abort_tick", sample(S_TICK), 0);
        chk("abort_chime", sample(S_CHIME), 0);
        @(negedge CP);
        CR = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            push(c, S_TICK, {31'd0, (c == 3 || c == 7)}, "tick_after_rst");
            push(c, S_ACT, 0, "act_after_rst");
        end
        push(4, S_TIME, t(0, 0, 1), "time_after_rst");
        goto(9);
        drain("abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_alarm_timekeeper.md
MULTI_ALARM_TIMEKEEPER -- requirements
Module: multi_alarm_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, CP cycles per second tick (>=2).
REQ-002 SHALL have parameter N_ALARM, default 4, number of independent alarm channels (1..8).
REQ-003 SHALL have parameter RING_SEC, default 30, seconds an alarm rings before self-clearing.
REQ-004 SHALL have parameter SNOOZE_SEC, default 300, seconds from snooze to re-ring.
REQ-005 SHALL have parameter BEEP_DIV, default 2, CP cycles per half-period of the buzzer tone.
REQ-006 SHALL have port CP  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have port CR  input  1  asynchronous active-high reset.
REQ-008 SHALL have port adj_min  input  1  one-cycle pulse, advance minute.
REQ-009 SHALL have port adj_hr  input  1  one-cycle pulse, advance hour.
REQ-010 SHALL have port al_wr  input  1  write alarm time for channel al_sel.
REQ-011 SHALL have port al_sel  input  clog2(N_ALARM) (min 1)  alarm channel index.
REQ-012 SHALL have port al_hr / al_min  input  8 each  BCD alarm hour / minute.
REQ-013 SHALL have port al_en  input  N_ALARM  per-channel alarm enable, level.
REQ-014 SHALL have port snooze  input  1  one-cycle pulse, snooze all ringing channels.
REQ-015 SHALL have port hour / minute / second  output  8 each  BCD time, registered.
REQ-016 SHALL have port tick_1hz  output  1  one-cycle pulse per second.
REQ-017 SHALL have port alarm_active  output  N_ALARM  per-channel ringing flag.
REQ-018 SHALL have port alarm_out / chime  output  1 each  buzzer tone / hourly chime.

Function
REQ-019 Prescaler SHALL count 0..TICK_DIV-1; tick_1hz=1 in the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-020 On tick, second SHALL increment BCD 00..59; 59->00 carries to minute 00..59; 59->00 carries to hour 00..23; 23:59:59->00:00:00.
REQ-021 adj_min SHALL increment minute (59->00, no hour carry) one cycle later; adj_hr SHALL increment hour (23->00); seconds unaffected.
REQ-022 Adjust in same cycle as tick carry: seconds still advance, the adjusted field takes adjust result only (carry into that field dropped).
REQ-023 al_wr SHALL store al_hr/al_min into channel al_sel unless non-BCD, hour>23 or minute>59 (write ignored); al_sel>=N_ALARM ignored.
REQ-024 Per-channel states IDLE, RING, SNOOZE; IDLE->RING when al_en[i]=1 and the tick yields HH:MM:00 equal to stored time.
REQ-025 RING SHALL hold RING_SEC ticks then ->IDLE; snooze pulse in RING ->SNOOZE loading SNOOZE_SEC countdown; countdown 0 on tick ->RING (ring timer reloaded).
REQ-026 al_en[i]=0 SHALL force channel i to IDLE next cycle from any state; snooze while IDLE/SNOOZE has no effect.
REQ-027 alarm_active[i]=1 exactly in RING; al_wr to a ringing channel SHALL not end the current ring.
REQ-028 alarm_out SHALL toggle every BEEP_DIV cycles while any alarm_active bit is 1, else 0; toggle counter restarts at 0 on first ring.
REQ-029 adj_min/adj_hr landing on an alarm time SHALL NOT trigger it (trigger only from tick).

Reset
REQ-030 CR=1 SHALL immediately clear time to 00:00:00, prescaler, all alarm registers to 00:00, all channels IDLE, all counters, and all outputs to 0.
REQ-031 CR asserted mid-ring or mid-snooze SHALL abort it; first tick after release occurs TICK_DIV cycles later.

Configuration
REQ-032 Macro HOURLY_CHIME_EN defined: chime=1 while minute=59 and second in {51,53,55,57,59}, registered with the time.
REQ-033 Macro HOURLY_CHIME_EN undefined: chime tied to 0, no chime logic present.

Verification (TICK_DIV=4, RING_SEC=3, SNOOZE_SEC=2, BEEP_DIV=2)
REQ-034 Reset release, 240 cycles -> tick_1hz every 4th cycle, time 00:01:00.
REQ-035 Preload 23:59:58 via adjusts, 2 ticks -> 00:00:00; adj_min at minute 59 -> minute 00, hour unchanged.
REQ-036 Channel 1 alarm 00:01, al_en=2'b10 -> alarm_active=0010 at 00:01:00 for 3 ticks; alarm_out toggles every 2 cycles, then 0.
REQ-037 Snooze during ring -> alarm_active 0 next cycle, re-asserts after 2 ticks; al_en cleared in SNOOZE -> never re-rings.
REQ-038 al_wr with al_hr=8'h24 or al_min=8'h5A -> stored value unchanged; CR mid-ring -> all outputs 0 immediately.
REQ-039 HOURLY_CHIME_EN defined: chime high at xx:59:51,53,55,57,59 only; undefined: chime constant 0.
